scratchpad_copy_master: RTL

Avalon-MM master that moves blocks of 32-bit words within a processor's 4096-word single-port scratchpad, programmed through a small CSR slave. It drives the scratchpad's s2 port directly: zero wait states, registered address, unregistered output, so read data is valid the cycle after the address. Software sets source, destination and length, then starts the copy. The block reports busy/done/error and raises an optional interrupt.

---
 rtl/scratchpad_copy_master.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/scratchpad_copy_master.sv
// Avalon-MM copy engine moving 32-bit words within a 4096-word scratchpad.
// Programmed through a 4-register CSR slave; one word per RD/CAP/WR triple.
module scratchpad_copy_master #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 13
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        csr_address,
    input  logic              csr_chipselect,
    input  logic              csr_read,
    input  logic              csr_write,
    input  logic [31:0]       csr_writedata,
    output logic [31:0]       csr_readdata,
    output logic              irq,
    output logic [ADDR_W-1:0] spm_address,
    output logic              spm_chipselect,
    output logic              spm_write,
    output logic [3:0]        spm_byteenable,
    output logic [DATA_W-1:0] spm_writedata,
    input  logic [DATA_W-1:0] spm_readdata,
    output logic              spm_clken
);

    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(2 ** ADDR_W);

    typedef enum logic [1:0] {IDLE, RD, CAP, WR} state_t;

    state_t state, state_nxt;

    logic [ADDR_W-1:0] src_reg, dst_reg, wsrc, wdst;
    logic [LEN_W-1:0]  len_reg, count;
    logic [DATA_W-1:0] data_reg;
    logic              irq_en, done, error;
    logic              ctrl_wr, start_req, abort_req, busy;
    logic              len_bad, len_zero, last_word, launch;
    logic              unused_wdata;

    assign ctrl_wr   = csr_chipselect & csr_write & (csr_address == 2'd0);
    assign abort_req = ctrl_wr & csr_writedata[2];
    // Abort in the same write suppresses the start.
    assign start_req = ctrl_wr & csr_writedata[0] & ~csr_writedata[2];
    assign busy      = (state != IDLE);
    assign len_bad   = (len_reg > MAX_LEN);
    assign len_zero  = (len_reg == '0);
    assign last_word = (count == LEN_W'(1));
    assign launch    = ~busy & start_req & ~len_bad & ~len_zero;

    assign irq            = done & irq_en;
    assign spm_byteenable = 4'hF;
    assign spm_clken      = 1'b1;
    assign unused_wdata   = ^csr_writedata[31:LEN_W];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (launch) state_nxt = RD;
            RD:   state_nxt = abort_req ? IDLE : CAP;
            CAP:  state_nxt = abort_req ? IDLE : WR;
            WR:   state_nxt = (abort_req || last_word) ? IDLE : RD;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        spm_chipselect = 1'b0;
        spm_write      = 1'b0;
        spm_address    = '0;
        spm_writedata  = '0;
        case (state)
            RD: begin
                spm_chipselect = 1'b1;
                spm_address    = wsrc;
            end
            WR: begin
                spm_chipselect = 1'b1;
                spm_write      = 1'b1;
                spm_address    = wdst;
                spm_writedata  = data_reg;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            src_reg  <= '0;
            dst_reg  <= '0;
            len_reg  <= '0;
            irq_en   <= 1'b0;
            done     <= 1'b0;
            error    <= 1'b0;
            wsrc     <= '0;
            wdst     <= '0;
            count    <= '0;
            data_reg <= '0;
        end else begin
            if (csr_chipselect && csr_write && !busy) begin
                case (csr_address)
                    2'd1:    src_reg <= csr_writedata[ADDR_W-1:0];
                    2'd2:    dst_reg <= csr_writedata[ADDR_W-1:0];
                    2'd3:    len_reg <= csr_writedata[LEN_W-1:0];
                    default: ;
                endcase
            end
            if (ctrl_wr) irq_en <= csr_writedata[3];
            if (ctrl_wr && csr_writedata[1]) done <= 1'b0;

            // Later branches override the done-clear above.
            if (busy && abort_req) begin
                done  <= 1'b0;
                error <= 1'b1;
            end else if (state == WR && last_word) begin
                done <= 1'b1;
            end else if (!busy && start_req) begin
                if (len_bad) begin
                    done  <= 1'b0;
                    error <= 1'b1;
                end else if (len_zero) begin
                    done  <= 1'b1;
                    error <= 1'b0;
                end else begin
                    done  <= 1'b0;
                    error <= 1'b0;
                end
            end

            if (launch) begin
                wsrc  <= src_reg;
                wdst  <= dst_reg;
                count <= len_reg;
            end else if (state == WR) begin
                wsrc  <= wsrc + 1'b1;
                wdst  <= wdst + 1'b1;
                count <= count - 1'b1;
            end

            if (state == CAP) data_reg <= spm_readdata;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            csr_readdata <= '0;
        end else if (csr_chipselect && csr_read) begin
            case (csr_address)
                2'd0:    csr_readdata <= {28'd0, irq_en, error, done, busy};
                2'd1:    csr_readdata <= {{(32-ADDR_W){1'b0}}, src_reg};
                2'd2:    csr_readdata <= {{(32-ADDR_W){1'b0}}, dst_reg};
                default: csr_readdata <= {{(32-LEN_W){1'b0}}, len_reg};
            endcase
        end
    end

endmodule
